// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor with a HALF (bitwise sum/carry) mode.
// The carry chain is cut into SEG-bit segments with one register stage each.
// Register index 0 holds the accepted operands. Index k+1 holds the beat
// after segment k has been resolved. Index STAGES drives the outputs.
// A single global advance moves every stage together; it is driven by the
// output handshake alone.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cvec,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_HALF    = 2'b10,
    OP_ADD_CIN = 2'b11
  } op_e;

  // Whole pipeline moves when the output slot is empty or being drained
  logic adv;

  // Operand decode at the accept point
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             half0;

  // Stage state. Operands (skew) only needed up to the last adding stage.
  logic [STAGES:0]   vld_q;
  logic [STAGES:0]   c_q;
  logic [STAGES-1:0] half_q;
  logic [WIDTH-1:0]  a_q  [0:STAGES-1];
  logic [WIDTH-1:0]  b_q  [0:STAGES-1];
  logic [WIDTH-1:0]  s_q  [0:STAGES];
  logic [WIDTH-1:0]  cv_q [0:STAGES];
  logic              ovf_q;

  // Next values produced by each segment adder (element k feeds index k+1)
  logic [WIDTH-1:0]  s_d  [0:STAGES-1];
  logic [WIDTH-1:0]  cv_d [0:STAGES-1];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;

  logic [SEG-1:0]    seg_a;
  logic [SEG-1:0]    seg_b;
  logic [SEG:0]      seg_sum;

  assign adv       = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cvec      = cv_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = ovf_q;

  // Effective second operand and stage-0 carry-in for the requested operation
  always_comb begin
    b_eff = b;
    c0    = 1'b0;
    half0 = 1'b0;
    case (op)
      OP_SUB: begin
        b_eff = ~b;
        c0    = 1'b1;
      end
      OP_ADD_CIN: c0 = cin;
      OP_HALF:    half0 = 1'b1;
      default: ;
    endcase
  end

  // Segment adders: stage k resolves bits [k*SEG +: SEG] using the carry from stage k-1
  always_comb begin
    seg_a   = '0;
    seg_b   = '0;
    seg_sum = '0;
    ovf_d   = 1'b0;
    c_d     = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_a   = a_q[k][k*SEG +: SEG];
      seg_b   = b_q[k][k*SEG +: SEG];
      seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, c_q[k]};
      s_d[k]  = s_q[k];
      cv_d[k] = cv_q[k];
      if (half_q[k]) begin
        s_d[k][k*SEG +: SEG]  = seg_a ^ seg_b;
        cv_d[k][k*SEG +: SEG] = seg_a & seg_b;
        c_d[k]                = 1'b0;
      end else begin
        s_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
        cv_d[k][k*SEG +: SEG] = '0;
        c_d[k]                = seg_sum[SEG];
      end
    end
    // Signed overflow: operands agree in sign but the result does not
    ovf_d = !half_q[STAGES-1]
            && (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
            && (s_d[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: clear on reset, otherwise shift all stages together on adv
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      half_q <= '0;
      ovf_q  <= 1'b0;
      for (int k = 0; k <= STAGES; k++) begin
        s_q[k]  <= '0;
        cv_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      a_q[0]    <= a;
      b_q[0]    <= b_eff;
      c_q[0]    <= c0;
      half_q[0] <= half0;
      s_q[0]    <= '0;
      cv_q[0]   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k+1] <= vld_q[k];
        s_q[k+1]   <= s_d[k];
        cv_q[k+1]  <= cv_d[k];
        c_q[k+1]   <= c_d[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        half_q[k] <= half_q[k-1];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 32/8 instance, then random
// streams with random backpressure on 64/16 and 8/8 instances against a
// plain-arithmetic reference model.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [1:0]  op;
  logic [31:0] a, b, sum, cvec;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  bit start_rand = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  pipelined_adder #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cvec(cvec), .cout(cout), .ovf(ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One isolated beat on the 32/8 instance, checked against constants
  task automatic run_one(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic c, input logic [31:0] es,
                         input logic [31:0] ecv, input logic ec, input logic eo);
    int acc;
    int n;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; cin = c; out_ready = 1'b1;
    #1;
    check_val({tag, "_rdy"}, in_ready, 1);
    acc = edge_cnt + 1;
    @(negedge clk);
    // operand/op/cin changes without an accept must not matter
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; op = ~o; cin = ~c;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_lat"}, 64'(edge_cnt - acc), 4);
    check_val({tag, "_sum"}, sum, es);
    check_val({tag, "_cvec"}, cvec, ecv);
    check_val({tag, "_cout"}, cout, ec);
    check_val({tag, "_ovf"}, ovf, eo);
    $display("beat %s: a=%08h b=%08h op=%0d -> sum=%08h cvec=%08h cout=%0b ovf=%0b",
             tag, x, y, o, sum, cvec, cout, ovf);
  endtask

  // Random sweep instances
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int W  = (gi == 0) ? 64 : 8;
      localparam int S  = (gi == 0) ? 16 : 8;
      localparam int ST = W / S;

      logic         iv, ir, ov, ordy, ci, co, of;
      logic [1:0]   opv;
      logic [W-1:0] av, bv, sv, cvv;
      bit           done = 1'b0;

      logic [W-1:0] q_s[$];
      logic [W-1:0] q_cv[$];
      bit           q_c[$];
      bit           q_o[$];
      int           q_e[$];
      int           q_st[$];

      pipelined_adder #(.WIDTH(W), .SEG(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .a(av), .b(bv), .cin(ci), .op(opv), .out_valid(ov),
        .out_ready(ordy), .sum(sv), .cvec(cvv), .cout(co), .ovf(of)
      );

      // Reference: plain wide arithmetic, signed overflow from a sign-extended result
      function automatic void model(input logic [1:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input logic c,
                                    output logic [W-1:0] s, output logic [W-1:0] cv,
                                    output logic co_o, output logic ov_o);
        logic [W:0] u;
        logic [W:0] sx;
        logic       ce;
        s = '0; cv = '0; co_o = 1'b0; ov_o = 1'b0; u = '0; sx = '0;
        ce = (o == 2'b11) ? c : 1'b0;
        case (o)
          2'b10: begin
            s  = x ^ y;
            cv = x & y;
          end
          2'b01: begin
            s    = x - y;
            co_o = (x >= y);
            sx   = {x[W-1], x} - {y[W-1], y};
            ov_o = sx[W] ^ sx[W-1];
          end
          default: begin
            u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ce};
            s    = u[W-1:0];
            co_o = u[W];
            sx   = {x[W-1], x} + {y[W-1], y} + {{W{1'b0}}, ce};
            ov_o = sx[W] ^ sx[W-1];
          end
        endcase
      endfunction

      initial begin : eng
        int          n_acc;
        int          stall_cnt;
        bit          held_prev;
        logic [63:0] r64;
        logic [W-1:0] es, ecv;
        logic        ec, eo;
        string       tg;
        tg = $sformatf("w%0d", W);
        iv = 1'b0; ordy = 1'b1; av = '0; bv = '0; opv = 2'b00; ci = 1'b0;
        wait (start_rand);
        n_acc = 0; stall_cnt = 0; held_prev = 1'b0;
        for (int cyc = 0; cyc < 20000 && !(n_acc >= 1000 && q_s.size() == 0); cyc++) begin
          @(negedge clk);
          iv   = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
          r64  = {$urandom(), $urandom()};
          av   = r64[W-1:0];
          r64  = {$urandom(), $urandom()};
          bv   = r64[W-1:0];
          if ($urandom_range(0, 7) == 0) av = '1;
          if ($urandom_range(0, 7) == 0) bv = (opv == 2'b01) ? '0 : '1;
          opv  = 2'($urandom_range(0, 3));
          ci   = 1'($urandom_range(0, 1));
          ordy = ($urandom_range(0, 3) != 0) || (n_acc >= 1000);
          #1;
          check_val({tg, "_rdy"}, ir, !ov || ordy);
          if (q_s.size() == 0) begin
            check_val({tg, "_idle"}, ov, 0);
          end else if (ov) begin
            if (!held_prev)
              check_val({tg, "_lat"}, 64'(edge_cnt - q_e[0]), 64'(ST + stall_cnt - q_st[0]));
            check_val({tg, "_sum"}, sv, q_s[0]);
            check_val({tg, "_cvec"}, cvv, q_cv[0]);
            check_val({tg, "_cout"}, co, q_c[0]);
            check_val({tg, "_ovf"}, of, q_o[0]);
            if (ordy) begin
              $display("%s out: sum=%0h cvec=%0h cout=%0b ovf=%0b", tg, sv, cvv, co, of);
              void'(q_s.pop_front()); void'(q_cv.pop_front());
              void'(q_c.pop_front()); void'(q_o.pop_front());
              void'(q_e.pop_front()); void'(q_st.pop_front());
            end
          end
          held_prev = ov && !ordy;
          if (ov && !ordy) stall_cnt++;
          if (iv && ir) begin
            model(opv, av, bv, ci, es, ecv, ec, eo);
            q_s.push_back(es); q_cv.push_back(ecv); q_c.push_back(ec); q_o.push_back(eo);
            q_e.push_back(edge_cnt + 1); q_st.push_back(stall_cnt);
            n_acc++;
          end
        end
        check_val({tg, "_drain"}, 64'(q_s.size()), 0);
        check_val({tg, "_nacc"}, 64'(n_acc), 1000);
        done = 1'b1;
      end
    end
  endgenerate

  initial begin : main
    logic [31:0] hold_sum;
    bit          held;
    int          sent;
    int          got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 2'b00; cin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_ovalid", out_valid, 0);
    check_val("rst_sum", sum, 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_irdy", in_ready, 1);

    // Directed single beats
    run_one("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'h0, 1'b1, 1'b0);
    run_one("sub_brw",  2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    run_one("sub_ovf",  2'b01, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1);
    run_one("half",     2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0, 32'hF000F000, 1'b0, 1'b0);
    run_one("addcin",   2'b11, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b1);
    run_one("add_nocin", 2'b00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 32'h0, 1'b0, 1'b0);

    // Streaming with a 3-cycle output stall mid-stream
    sent = 0; got = 0; held = 1'b0; hold_sum = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      a         = 32'(sent);
      b         = 32'(sent) * 32'h01010101;
      op        = 2'b00;
      cin       = 1'b0;
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc < 16) check_val("strm_irdy", in_ready, !(cyc >= 6 && cyc <= 8));
      if (held) check_val("strm_hold", sum, hold_sum);
      if (out_valid && out_ready) begin
        check_val("strm_sum", sum, 32'(got) + 32'(got) * 32'h01010101);
        $display("stream out %0d: sum=%08h", got, sum);
        got++;
      end
      held     = out_valid && !out_ready;
      hold_sum = sum;
      if (in_valid && in_ready) sent++;
    end
    check_val("strm_cnt", 64'(got), 8);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(k + 1); b = 32'd5; op = 2'b00; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mrst_ovalid", out_valid, 0);
    check_val("mrst_sum", sum, 0);
    check_val("mrst_cvec", cvec, 0);
    check_val("mrst_cout", cout, 0);
    check_val("mrst_ovf", ovf, 0);
    check_val("mrst_irdy", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("mrst_stale", out_valid, 0);
    end
    run_one("post_rst", 2'b00, 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 32'h0, 1'b0, 1'b0);

    // Random parameter sweep
    start_rand = 1'b1;
    for (int k = 0; k < 30000 && !(g_sweep[0].done && g_sweep[1].done); k++) @(negedge clk);
    check_val("sweep_done", {62'd0, g_sweep[0].done, g_sweep[1].done}, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined W-bit adder. It generalises the team's 8-bit bitwise half-adder bank to any width and adds carry propagation, subtraction, carry-in, overflow and a valid/ready handshake. The carry chain is split into SEG-bit segments with one register stage per segment, so wide additions (e.g. 32-bit modular adds in the hash datapath) close timing on the FPGA. A HALF mode reproduces the legacy per-bit sum/carry behaviour for existing consumers.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, segment width; pipeline depth STAGES = WIDTH/SEG (≥1).
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only in ADD_CIN.
- op  input  2  00 ADD, 01 SUB, 10 HALF, 11 ADD_CIN.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cvec  output  WIDTH  per-bit carry vector (HALF mode only, else 0).
- cout  output  1  carry-out of MSB (ADD/SUB/ADD_CIN), 0 in HALF.
- ovf  output  1  signed two's-complement overflow (ADD/SUB/ADD_CIN), 0 in HALF.

## Operation
- ADD: sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of the true sum.
- SUB: computed as a + ~b + 1; cout = 1 means no borrow.
- ADD_CIN: sum = a+b+cin.
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the effective second operand (~b in SUB).
- HALF: sum = a^b, cvec = a&b bitwise, no propagation, cout = ovf = 0.
- Stage k (0..STAGES-1) adds segment k of the operands plus the carry registered from stage k-1. Stage 0 carry-in is 0 (ADD), 1 (SUB) or cin (ADD_CIN). Upper operand segments and op travel in skew registers alongside the beat; finished lower segments travel in deskew registers.
- Each stage holds a valid bit. Beats stay strictly in order; no reordering or dropping.
- Global advance signal: adv = !out_valid || out_ready. When adv=1 every stage shifts by one. When adv=0 all stages, including the output, hold.
- in_ready = adv. A beat is accepted iff in_valid && in_ready.
- Bubbles travel with the pipeline and are not collapsed.

## Timing
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+STAGES, provided no stall occurs. Each stall cycle adds one.
- Throughput: one beat per cycle while out_ready=1.
- Output registers are held stable while out_valid && !out_ready (sum, cvec, cout and ovf must not change).
- in_ready is combinational from out_valid/out_ready; there is no combinational path from in_valid to any output.
- Reset: on the edge where rst_n=0, all stage valid bits clear and out_valid=0. sum, cvec, cout and ovf are 0, and in_ready=1 once rst_n is high.
- Reset mid-operation: in-flight beats are discarded and none are emitted after release.
- Simultaneous accept and emit in the same cycle is legal and is the steady-state case.
- STAGES=1 (SEG=WIDTH): latency is 1, same handshake rules.
- op and cin are sampled only on accept. Changes while no beat is accepted have no effect.

## Test plan
- ADD, WIDTH=32/SEG=8: a=FFFFFFFF, b=00000001 -> after 4 cycles sum=00000000, cout=1, ovf=0, cvec=0.
- SUB: a=00000000, b=00000001 -> sum=FFFFFFFF, cout=0, ovf=0. Then a=80000000, b=00000001 -> sum=7FFFFFFF, cout=1, ovf=1.
- HALF: a=F0F0F0F0, b=FF00FF00 -> sum=0FF00FF0, cvec=F000F000, cout=0, ovf=0. ADD_CIN: a=7FFFFFFF, b=0, cin=1 -> sum=80000000, ovf=1, cout=0.
- Streaming with backpressure: 8 back-to-back ADD beats (a=i, b=i·0x01010101), out_ready low for 3 cycles mid-stream -> in_ready low in exactly those cycles, output held stable, all 8 results in order, none duplicated.
- Reset mid-operation: 3 beats in flight, rst_n low 1 cycle -> next cycle out_valid=0 and all outputs 0, no stale beat emitted afterwards, a new beat then completes in 4 cycles.
- Parameter sweep: WIDTH=64/SEG=16 and WIDTH=8/SEG=8 with 1000 random beats and random out_ready -> every result matches the reference model, latency equals STAGES plus stall cycles.
